// File: rtl/axis_pkg.sv
// Shared definitions for the byte packer: state encoding, lane/bit helpers,
// and keep <-> byte-count conversion functions.
package axis_pkg;

    typedef enum logic [0:0] {
        ST_PASS  = 1'b0,
        ST_FLUSH = 1'b1
    } pack_state_e;

    localparam int BYTE_WD   = 8;
    localparam int MAX_LANES = 64;
    localparam int MAX_BITS  = MAX_LANES * BYTE_WD;

    function automatic int lanes_to_bits(input int lanes);
        return lanes * BYTE_WD;
    endfunction

    // Leading ones counted from lane (lanes-1) downward; stops at the first zero.
    function automatic int keep_to_cnt_lead(input logic [MAX_LANES-1:0] keep, input int lanes);
        int   cnt;
        logic run;
        cnt = 0;
        run = 1'b1;
        for (int i = MAX_LANES - 1; i >= 0; i--) begin
            run = run & ((i >= lanes) | keep[i]);
            cnt = cnt + (((i < lanes) && run) ? 1 : 0);
        end
        return cnt;
    endfunction

    function automatic int keep_to_cnt_pop(input logic [MAX_LANES-1:0] keep, input int lanes);
        int cnt;
        cnt = 0;
        for (int i = 0; i < MAX_LANES; i++) begin
            cnt = cnt + (((i < lanes) && keep[i]) ? 1 : 0);
        end
        return cnt;
    endfunction

    // Mask with the top cnt lanes (of lanes) set.
    function automatic logic [MAX_LANES-1:0] cnt_to_keep(input int cnt, input int lanes);
        logic [MAX_LANES-1:0] mask;
        for (int i = 0; i < MAX_LANES; i++) begin
            mask[i] = (i < lanes) && (i >= lanes - cnt);
        end
        return mask;
    endfunction

    function automatic logic [MAX_BITS-1:0] keep_to_mask(input logic [MAX_LANES-1:0] keep);
        logic [MAX_BITS-1:0] mask;
        for (int i = 0; i < MAX_LANES; i++) begin
            mask[i*BYTE_WD +: BYTE_WD] = {BYTE_WD{keep[i]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/axis_keep_count.sv
// Converts a keep vector into a byte count and a legality flag.
// With PACKER_KEEP_CHECK_EN the count is the MSB-contiguous run; otherwise a popcount.
module axis_keep_count
    import axis_pkg::*;
#(
    parameter int DATA_BYTE_WD = 4,
    parameter int CNT_WD       = $clog2(DATA_BYTE_WD) + 1
) (
    input  logic [DATA_BYTE_WD-1:0] keep,
    output logic [CNT_WD-1:0]       cnt,
    output logic                    legal
);

    // Legal keep is exactly the top-N mask implied by its own leading-ones count.
    always_comb begin
`ifdef PACKER_KEEP_CHECK_EN
        cnt   = CNT_WD'(keep_to_cnt_lead(MAX_LANES'(keep), DATA_BYTE_WD));
        legal = (DATA_BYTE_WD'(cnt_to_keep(int'(cnt), DATA_BYTE_WD)) == keep);
`else
        cnt   = CNT_WD'(keep_to_cnt_pop(MAX_LANES'(keep), DATA_BYTE_WD));
        legal = 1'b1;
`endif
    end

endmodule

// File: rtl/axi_stream_byte_packer.sv
// Re-packs MSB-aligned partial AXI-Stream beats into full beats; only the packet's
// final beat may be partial. Optional keep legality checking via PACKER_KEEP_CHECK_EN.
module axi_stream_byte_packer
    import axis_pkg::*;
#(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int CNT_WD       = $clog2(DATA_BYTE_WD) + 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    valid_in,
    input  logic [DATA_WD-1:0]      data_in,
    input  logic [DATA_BYTE_WD-1:0] keep_in,
    input  logic                    last_in,
    output logic                    ready_in,
    output logic                    valid_out,
    output logic [DATA_WD-1:0]      data_out,
    output logic [DATA_BYTE_WD-1:0] keep_out,
    output logic                    last_out,
    input  logic                    ready_out,
    output logic                    err_keep
);

    localparam int              TOT_WD  = CNT_WD + 1;
    localparam logic [TOT_WD-1:0] LANES_L = TOT_WD'(DATA_BYTE_WD);

    pack_state_e               state_q, state_d;
    logic [DATA_WD-1:0]        res_data_q, res_data_d;
    logic [CNT_WD-1:0]         res_cnt_q, res_cnt_d;
    logic                      valid_q, valid_d;
    logic [DATA_WD-1:0]        data_q, data_d;
    logic [DATA_BYTE_WD-1:0]   keep_q, keep_d;
    logic                      last_q, last_d;
    logic                      err_q, err_d;

    logic [CNT_WD-1:0]         n_s;
    logic                      legal_s;
    logic                      out_free_s;
    logic                      accept_s;
    logic [TOT_WD-1:0]         total_s;
    logic [TOT_WD-1:0]         over_s;
    logic [DATA_WD-1:0]        in_mask_s;
    logic [DATA_WD-1:0]        in_data_s;
    logic [2*DATA_WD-1:0]      comb_s;
    logic [DATA_BYTE_WD-1:0]   total_keep_s;
    logic [DATA_BYTE_WD-1:0]   res_keep_s;

    axis_keep_count #(
        .DATA_BYTE_WD (DATA_BYTE_WD),
        .CNT_WD       (CNT_WD)
    ) u_keep_count (
        .keep  (keep_in),
        .cnt   (n_s),
        .legal (legal_s)
    );

    assign out_free_s = !valid_q || ready_out;
    assign ready_in   = (state_q == ST_PASS) && out_free_s;
    assign accept_s   = valid_in && ready_in;

    // Residual bytes occupy the top lanes of the upper half; the input follows them.
    always_comb begin
        total_s      = {1'b0, res_cnt_q} + {1'b0, n_s};
        over_s       = total_s - LANES_L;
        in_mask_s    = DATA_WD'(keep_to_mask(cnt_to_keep(int'(n_s), DATA_BYTE_WD)));
        in_data_s    = data_in & in_mask_s;
        comb_s       = {res_data_q, {DATA_WD{1'b0}}}
                     | ({in_data_s, {DATA_WD{1'b0}}} >> lanes_to_bits(int'(res_cnt_q)));
        total_keep_s = DATA_BYTE_WD'(cnt_to_keep(int'(total_s), DATA_BYTE_WD));
        res_keep_s   = DATA_BYTE_WD'(cnt_to_keep(int'(res_cnt_q), DATA_BYTE_WD));
    end

    // Next-state, residual and output-register computation.
    always_comb begin
        state_d    = state_q;
        res_data_d = res_data_q;
        res_cnt_d  = res_cnt_q;
        valid_d    = valid_q && !ready_out;
        data_d     = data_q;
        keep_d     = keep_q;
        last_d     = last_q;
        err_d      = err_q;

        case (state_q)
            ST_PASS: begin
                if (accept_s) begin
                    err_d = err_q | ~legal_s;
                    if (!last_in) begin
                        if (total_s < LANES_L) begin
                            res_data_d = comb_s[2*DATA_WD-1:DATA_WD];
                            res_cnt_d  = total_s[CNT_WD-1:0];
                        end else begin
                            valid_d    = 1'b1;
                            data_d     = comb_s[2*DATA_WD-1:DATA_WD];
                            keep_d     = {DATA_BYTE_WD{1'b1}};
                            last_d     = 1'b0;
                            res_data_d = comb_s[DATA_WD-1:0];
                            res_cnt_d  = over_s[CNT_WD-1:0];
                        end
                    end else if (total_s <= LANES_L) begin
                        valid_d    = 1'b1;
                        data_d     = comb_s[2*DATA_WD-1:DATA_WD];
                        keep_d     = total_keep_s;
                        last_d     = 1'b1;
                        res_data_d = {DATA_WD{1'b0}};
                        res_cnt_d  = {CNT_WD{1'b0}};
                    end else begin
                        // Packet end spills past one beat: send a full beat now, tail later.
                        valid_d    = 1'b1;
                        data_d     = comb_s[2*DATA_WD-1:DATA_WD];
                        keep_d     = {DATA_BYTE_WD{1'b1}};
                        last_d     = 1'b0;
                        res_data_d = comb_s[DATA_WD-1:0];
                        res_cnt_d  = over_s[CNT_WD-1:0];
                        state_d    = ST_FLUSH;
                    end
                end else begin
                    state_d = ST_PASS;
                end
            end
            ST_FLUSH: begin
                if (out_free_s) begin
                    valid_d    = 1'b1;
                    data_d     = res_data_q;
                    keep_d     = res_keep_s;
                    last_d     = 1'b1;
                    res_data_d = {DATA_WD{1'b0}};
                    res_cnt_d  = {CNT_WD{1'b0}};
                    state_d    = ST_PASS;
                end else begin
                    state_d = ST_FLUSH;
                end
            end
            default: begin
                state_d    = ST_PASS;
                res_data_d = {DATA_WD{1'b0}};
                res_cnt_d  = {CNT_WD{1'b0}};
                valid_d    = 1'b0;
            end
        endcase
    end

    // State, residual and registered outputs; reset drops any in-flight packet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_PASS;
            res_data_q <= {DATA_WD{1'b0}};
            res_cnt_q  <= {CNT_WD{1'b0}};
            valid_q    <= 1'b0;
            data_q     <= {DATA_WD{1'b0}};
            keep_q     <= {DATA_BYTE_WD{1'b0}};
            last_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            res_data_q <= res_data_d;
            res_cnt_q  <= res_cnt_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
            keep_q     <= keep_d;
            last_q     <= last_d;
            err_q      <= err_d;
        end
    end

    assign valid_out = valid_q;
    assign data_out  = data_q;
    assign keep_out  = keep_q;
    assign last_out  = last_q;
    assign err_keep  = err_q;

endmodule

// File: tb/tb_axi_stream_byte_packer.sv
// Directed and randomized bench for axi_stream_byte_packer against a byte-queue
// packet model. Build with PACKER_KEEP_CHECK_EN to exercise keep checking.
module tb_axi_stream_byte_packer;

    localparam int DW = 32;
    localparam int BW = 4;

`ifdef PACKER_KEEP_CHECK_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic          valid_in;
    logic [DW-1:0] data_in;
    logic [BW-1:0] keep_in;
    logic          last_in;
    logic          ready_in;
    logic          valid_out;
    logic [DW-1:0] data_out;
    logic [BW-1:0] keep_out;
    logic          last_out;
    logic          ready_out;
    logic          err_keep;

    axi_stream_byte_packer #(.DATA_WD(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_in  (valid_in),
        .data_in   (data_in),
        .keep_in   (keep_in),
        .last_in   (last_in),
        .ready_in  (ready_in),
        .valid_out (valid_out),
        .data_out  (data_out),
        .keep_out  (keep_out),
        .last_out  (last_out),
        .ready_out (ready_out),
        .err_keep  (err_keep)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
    } beat_t;

    beat_t       in_q[$];
    beat_t       exp_q[$];
    logic [7:0]  cur[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          first_in;
    int          first_out;
    int          rdy_low;
    logic [3:0]  kt [5];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Model: take the first c pending packet bytes as one MSB-aligned output beat.
    task automatic emit(input int c, input logic l);
        beat_t      b;
        logic [7:0] km;
        b.d = 32'h0;
        for (int j = 0; j < c; j++) b.d[31-8*j -: 8] = cur.pop_front();
        km  = 8'hF0 >> c;
        b.k = km[3:0];
        b.l = l;
        exp_q.push_back(b);
    endtask

    // Queue an input beat and update the expected output stream.
    task automatic push_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
        beat_t b;
        int    n;
        b.d = d; b.k = k; b.l = l;
        in_q.push_back(b);
        n = 0;
        for (int j = 3; j >= 0; j--) if (k[j] && n == 3 - j) n++;
        for (int j = 0; j < n; j++) cur.push_back(d[31-8*j -: 8]);
        if (!l) begin
            if (cur.size() >= 4) emit(4, 1'b0);
        end else if (cur.size() <= 4) begin
            emit(cur.size(), 1'b1);
        end else begin
            emit(4, 1'b0);
            emit(cur.size(), 1'b1);
        end
    endtask

    // Drive in_q, compare every accepted output beat, check stall stability.
    task automatic run(input int max_cyc, input bit rnd_rdy, input bit stop_on_in);
        int           cyc;
        bit           stalled;
        logic [36:0]  held;
        beat_t        e;
        cyc = 0; stalled = 1'b0; held = '0;
        first_in = -1; first_out = -1; rdy_low = 0;
        while (cyc < max_cyc && (stop_on_in ? (in_q.size() > 0) : (in_q.size() > 0 || exp_q.size() > 0))) begin
            @(negedge clk);
            if (in_q.size() > 0) begin
                valid_in = 1'b1; data_in = in_q[0].d; keep_in = in_q[0].k; last_in = in_q[0].l;
            end else begin
                valid_in = 1'b0; data_in = 32'h0; keep_in = 4'h0; last_in = 1'b0;
            end
            ready_out = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (stalled) chk("hold", 64'({valid_out, last_out, keep_out, data_out}), 64'({1'b1, held}));
            if (!ready_in) rdy_low++;
            if (valid_out && ready_out) begin
                if (exp_q.size() == 0) begin
                    chk("extra_beat", 64'({last_out, keep_out, data_out}), 64'h0);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat", 64'({last_out, keep_out, data_out}), 64'({e.l, e.k, e.d}));
                    if (first_out < 0) first_out = cyc;
                end
            end
            stalled = valid_out && !ready_out;
            held    = {last_out, keep_out, data_out};
            if (valid_in && ready_in) begin
                void'(in_q.pop_front());
                if (first_in < 0) first_in = cyc;
            end
            cyc++;
        end
        if (cyc >= max_cyc) chk("timeout", 64'(in_q.size() + (stop_on_in ? 0 : exp_q.size())), 64'h0);
        if (!stop_on_in) begin
            @(negedge clk);
            valid_in = 1'b0; ready_out = 1'b1;
            #1;
            chk("idle_valid", 64'(valid_out), 64'h0);
        end
    endtask

    task automatic push_s1();
        push_beat(32'hAABB0000, 4'b1100, 1'b0);
        push_beat(32'h11223344, 4'b1111, 1'b0);
        push_beat(32'h55667788, 4'b1111, 1'b1);
    endtask

    initial begin
        kt = '{4'h0, 4'h8, 4'hC, 4'hE, 4'hF};
        rst_n = 1'b0; valid_in = 1'b0; data_in = 32'h0; keep_in = 4'h0; last_in = 1'b0; ready_out = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_outputs", 64'({valid_out, last_out, keep_out, data_out}), 64'h0);
        chk("rst_err", 64'(err_keep), 64'h0);
        chk("rst_ready_in", 64'(ready_in), 64'h1);
        @(negedge clk);
        rst_n = 1'b1;

        // Header plus payload: exactly one FLUSH cycle with ready_in low.
        push_s1();
        run(200, 1'b0, 1'b0);
        chk("s1_ready_low", 64'(rdy_low), 64'h1);

        // Aligned packet: 1-cycle latency, no FLUSH.
        for (int i = 0; i < 3; i++) push_beat($urandom, 4'b1111, 1'(i == 2));
        run(200, 1'b0, 1'b0);
        chk("s2_latency", 64'(first_out - first_in), 64'h1);
        chk("s2_ready_low", 64'(rdy_low), 64'h0);

        // Zero header, then a lone empty last beat.
        push_beat(32'h00000000, 4'b0000, 1'b0);
        push_beat(32'hDEADBEEF, 4'b1111, 1'b1);
        run(200, 1'b0, 1'b0);
        push_beat(32'h12345678, 4'b0000, 1'b1);
        run(200, 1'b0, 1'b0);

        // Backpressure on the header-plus-payload packet.
        repeat (3) push_s1();
        run(600, 1'b1, 1'b0);

        // Random packets under random backpressure.
        for (int p = 0; p < 25; p++) begin
            int nb;
            nb = $urandom_range(1, 4);
            for (int b = 0; b < nb; b++) push_beat($urandom, kt[$urandom_range(0, 4)], 1'(b == nb - 1));
        end
        run(3000, 1'b1, 1'b0);

        // Reset mid-packet: pending beat and residual are discarded.
        push_beat(32'hAABB0000, 4'b1100, 1'b0);
        push_beat(32'h11223344, 4'b1111, 1'b0);
        run(50, 1'b0, 1'b1);
        @(negedge clk);
        valid_in = 1'b0;
        #1;
        chk("pre_reset_valid", 64'(valid_out), 64'h1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_outputs", 64'({valid_out, last_out, keep_out, data_out}), 64'h0);
        in_q.delete(); exp_q.delete(); cur.delete();
        @(negedge clk);
        rst_n = 1'b1;
        push_beat(32'h01020304, 4'b1111, 1'b1);
        run(200, 1'b0, 1'b0);

        // Non-contiguous keep: counted as one byte and flagged when checking is built in.
        @(negedge clk);
        valid_in = 1'b1; data_in = 32'hA1B2C3D4; keep_in = 4'b1011; last_in = 1'b1; ready_out = 1'b1;
        #1;
        chk("kc_ready", 64'(ready_in), 64'h1);
        @(posedge clk);
        #1;
        valid_in = 1'b0; data_in = 32'h0; keep_in = 4'h0; last_in = 1'b0;
        chk("kc_valid", 64'(valid_out), 64'h1);
        chk("kc_err_next", 64'(err_keep), 64'(ERR_EXP));
`ifdef PACKER_KEEP_CHECK_EN
        chk("kc_beat", 64'({last_out, keep_out, data_out}), 64'({1'b1, 4'b1000, 32'hA1000000}));
`endif
        @(posedge clk);
        #1;
        chk("kc_drained", 64'(valid_out), 64'h0);
        chk("kc_err_sticky", 64'(err_keep), 64'(ERR_EXP));
        push_s1();
        run(200, 1'b0, 1'b0);
        chk("kc_err_sticky2", 64'(err_keep), 64'(ERR_EXP));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/axi_stream_byte_packer.md
# axi_stream_byte_packer

Downstream stage of the header inserter: consumes an AXI-Stream whose beats carry MSB-aligned partial byte groups, such as a short header beat followed by payload beats. It re-packs bytes so that every output beat is full (keep all ones) except the final beat of a packet. The final beat is MSB-aligned with contiguous keep. Byte order is MSB-first: lane DATA_BYTE_WD-1 (data[DATA_WD-1 -: 8]) is the earliest byte.

## Interface
- DATA_WD, 32: data width in bits; a multiple of 8.
- DATA_BYTE_WD, DATA_WD/8: byte lanes.
- CNT_WD, $clog2(DATA_BYTE_WD)+1: width of byte counts, range 0..DATA_BYTE_WD.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- valid_in  in  1  input beat valid.
- data_in  in  DATA_WD  input data.
- keep_in  in  DATA_BYTE_WD  byte enables; contiguous ones from the MSB, or all zero.
- last_in  in  1  final beat of packet.
- ready_in  out  1  input accept.
- valid_out  out  1  output beat valid (registered).
- data_out  out  DATA_WD  packed data (registered).
- keep_out  out  DATA_BYTE_WD  packed keep (registered).
- last_out  out  1  packet end (registered).
- ready_out  in  1  downstream accept.
- err_keep  out  1  sticky illegal-keep flag (registered).

## Operation
- Residual register res_data (DATA_WD) and res_cnt (0..DATA_BYTE_WD-1) hold bytes not yet emitted. Residual bytes sit in the top res_cnt lanes.
- Input beat accepted when valid_in && ready_in. n = byte count of keep_in; total = res_cnt + n.
- Candidate beat cand: the res_cnt residual bytes in the top lanes, followed by the first DATA_BYTE_WD-res_cnt input bytes. Remaining input bytes become the new residual, shifted to the top lanes.
- Non-last beat, total < DATA_BYTE_WD: no output; res_cnt <= total.
- Non-last beat, total >= DATA_BYTE_WD: emit cand with keep all ones and last=0; res_cnt <= total-DATA_BYTE_WD.
- Last beat, total <= DATA_BYTE_WD: emit cand with keep = top total lanes set and last=1; res_cnt <= 0.
  - If total = 0, emit a zero-length beat: keep 0, data 0, last=1.
- Last beat, total > DATA_BYTE_WD: emit a full beat with last=0, store the remainder, enter FLUSH.
- Beats with keep 0 contribute no bytes; the header inserter emits these for byte_insert_cnt=0.
- Unused output lanes are driven 0.
- State machine:
  - PASS: normal accept.
  - FLUSH: ready_in=0. When the output register is free, emit the residual with keep = top res_cnt lanes and last=1; res_cnt <= 0; return to PASS.
- Arithmetic: total is at most 2*DATA_BYTE_WD-1 and is computed in CNT_WD+1 bits. Shifts are in whole bytes (count*8).

## Timing
- Reset values: valid_out 0, data_out 0, keep_out 0, last_out 0, err_keep 0, res_cnt 0, state PASS.
- Reset mid-packet discards the residual and the pending output beat.
- ready_in = (state==PASS) && (!valid_out || ready_out). This is combinational from ready_out and registered state only.
- Output register loads on the same edge as the accepted input. Latency is 1 cycle from the accepting edge to valid_out.
- Full throughput (one beat per cycle) in PASS with ready_out held high. A FLUSH costs one extra output cycle per packet.
- valid_out, data_out, keep_out and last_out are held stable while valid_out && !ready_out.
- valid_out clears on ready_out when no new beat is loaded.
- Back-to-back packets: the first beat of packet N+1 is accepted on the cycle after FLUSH emits.

## Configuration
- PACKER_KEEP_CHECK_EN defined:
  - Byte count n = number of leading ones from the MSB of keep_in.
  - Any accepted beat with keep_in not of that contiguous form sets err_keep; err_keep clears only on reset.
- PACKER_KEEP_CHECK_EN undefined:
  - n = popcount(keep_in).
  - err_keep is tied to 0.
  - Output for illegal keep is unspecified.

## Structure
- Shared package axis_pkg holds:
  - the state enum (PASS, FLUSH);
  - localparam helpers for byte/lane conversion;
  - functions keep_to_cnt (leading ones and popcount variants) and cnt_to_keep (top-N mask).
- One sub-module, axis_keep_count: keep → byte count plus legality flag, selected by PACKER_KEEP_CHECK_EN.

## Test plan
All scenarios use DATA_WD=32 unless stated.
- Header plus payload: 0xAABB0000/1100, 0x11223344/1111, 0x55667788/1111+last -> 0xAABB1122/1111, 0x33445566/1111, 0x77880000/1100+last; FLUSH entered once; ready_in low for one cycle.
- Aligned packet: keep 1111 on all beats, 3 beats with last on the third -> identical 3 beats out, 1-cycle latency, no FLUSH.
- Zero header and empty tail:
  - 0x00000000/0000 followed by 0xDEADBEEF/1111+last -> single beat 0xDEADBEEF/1111+last.
  - A lone keep-0000 last beat -> keep 0000, last=1 beat.
- Backpressure: ready_out toggled randomly during scenario 1 -> output sequence identical; outputs stable while stalled; no byte lost or duplicated.
- Reset mid-packet: assert rst_n=0 after the first payload beat -> all outputs 0 immediately. Next packet 0x01020304/1111+last -> 0x01020304/1111+last with no stale residual.
- Keep check, with PACKER_KEEP_CHECK_EN: keep 1011 -> err_keep=1 from the next cycle, sticky, and the beat is counted as 1 byte. Without the macro, err_keep stays 0.
